// File: rtl/timer_cfg_arbiter.sv
// rtl/timer_cfg_arbiter.sv - round-robin arbiter granting exclusive timer configuration ownership (optional TIMER_CFG_ARB_BOUNDARY_EN)
module timer_cfg_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int REGISTER_WIDTH  = 8,
  parameter int PRESCALER_WIDTH = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid,
  output logic [NUM_REQ-1:0]                        req_ready,
  input  logic [NUM_REQ-1:0]                        req_enable,
  input  logic [NUM_REQ-1:0]                        req_option,
  input  logic [NUM_REQ*PRESCALER_WIDTH-1:0]        req_prescaler,
  input  logic [NUM_REQ*2*REGISTER_WIDTH-1:0]       req_limit,
  input  logic [NUM_REQ-1:0]                        req_release,
  input  logic                                      timer_irq,
  output logic                                      tmr_enable_interrupt,
  output logic                                      tmr_interrupt_option,
  output logic [PRESCALER_WIDTH-1:0]                tmr_prescaler_selector,
  output logic [2*REGISTER_WIDTH-1:0]               tmr_limit_value,
  output logic                                      tmr_restart,
  output logic                                      owner_valid,
  output logic [((NUM_REQ>1)?$clog2(NUM_REQ):1)-1:0] owner_id,
  output logic [NUM_REQ-1:0]                        irq_out
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW  = 2 * REGISTER_WIDTH;
  localparam int PW  = PRESCALER_WIDTH;

`ifdef TIMER_CFG_ARB_BOUNDARY_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_id_q, owner_id_d;
  logic            owner_valid_q, owner_valid_d;
  logic            restart_q, restart_d;
  logic            act_en_q, act_en_d;
  logic            act_opt_q, act_opt_d;
  logic [PW-1:0]   act_psc_q, act_psc_d;
  logic [LW-1:0]   act_lim_q, act_lim_d;
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
  logic            sh_en_q, sh_en_d;
  logic            sh_opt_q, sh_opt_d;
  logic [PW-1:0]   sh_psc_q, sh_psc_d;
  logic [LW-1:0]   sh_lim_q, sh_lim_d;
`endif

  logic            win_found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  sel;
  logic            sel_en, sel_opt;
  logic [PW-1:0]   sel_psc;
  logic [LW-1:0]   sel_lim;

  // Round-robin search from rr_ptr+1; descending loop so the nearest valid requester wins last
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Field mux: the winner in IDLE, otherwise the current owner
  always_comb begin
    sel     = (state_q == S_IDLE) ? win : owner_id_q;
    sel_en  = req_enable[sel];
    sel_opt = req_option[sel];
    sel_psc = req_prescaler[int'(sel)*PW +: PW];
    sel_lim = req_limit[int'(sel)*LW +: LW];
  end

  // Next-state, handshake and configuration load decisions
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_id_d    = owner_id_q;
    owner_valid_d = owner_valid_q;
    restart_d     = 1'b0;
    act_en_d      = act_en_q;
    act_opt_d     = act_opt_q;
    act_psc_d     = act_psc_q;
    act_lim_d     = act_lim_q;
    req_ready     = '0;
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
    sh_en_d       = sh_en_q;
    sh_opt_d      = sh_opt_q;
    sh_psc_d      = sh_psc_q;
    sh_lim_d      = sh_lim_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          req_ready[win] = 1'b1;
          act_en_d       = sel_en;
          act_opt_d      = sel_opt;
          act_psc_d      = sel_psc;
          act_lim_d      = sel_lim;
          owner_id_d     = win;
          owner_valid_d  = 1'b1;
          rr_ptr_d       = win;
          restart_d      = 1'b1;
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        req_ready[owner_id_q] = req_valid[owner_id_q];
        if (req_release[owner_id_q]) begin
          // Release wins over a same-cycle update from the owner
          act_en_d      = 1'b0;
          owner_valid_d = 1'b0;
          state_d       = S_IDLE;
        end else if (req_valid[owner_id_q]) begin
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
          sh_en_d  = sel_en;
          sh_opt_d = sel_opt;
          sh_psc_d = sel_psc;
          sh_lim_d = sel_lim;
          state_d  = S_PEND;
`else
          act_en_d  = sel_en;
          act_opt_d = sel_opt;
          act_psc_d = sel_psc;
          act_lim_d = sel_lim;
          restart_d = 1'b1;
`endif
        end
      end
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
      S_PEND: begin
        if (req_release[owner_id_q]) begin
          act_en_d      = 1'b0;
          owner_valid_d = 1'b0;
          sh_en_d       = 1'b0;
          sh_opt_d      = 1'b0;
          sh_psc_d      = '0;
          sh_lim_d      = '0;
          state_d       = S_IDLE;
        end else if (timer_irq || !act_en_q) begin
          // A stopped timer has no boundary to wait for, so commit immediately
          act_en_d  = sh_en_q;
          act_opt_d = sh_opt_q;
          act_psc_d = sh_psc_q;
          act_lim_d = sh_lim_q;
          state_d   = S_RUN;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  // Timer interrupt steered to the current owner only
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      irq_out[i] = !rst && timer_irq && owner_valid_q && (owner_id_q == IDW'(i));
    end
  end

  // State and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      owner_id_q    <= '0;
      owner_valid_q <= 1'b0;
      restart_q     <= 1'b0;
      act_en_q      <= 1'b0;
      act_opt_q     <= 1'b0;
      act_psc_q     <= '0;
      act_lim_q     <= '0;
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
      sh_en_q       <= 1'b0;
      sh_opt_q      <= 1'b0;
      sh_psc_q      <= '0;
      sh_lim_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_id_q    <= owner_id_d;
      owner_valid_q <= owner_valid_d;
      restart_q     <= restart_d;
      act_en_q      <= act_en_d;
      act_opt_q     <= act_opt_d;
      act_psc_q     <= act_psc_d;
      act_lim_q     <= act_lim_d;
`ifdef TIMER_CFG_ARB_BOUNDARY_EN
      sh_en_q       <= sh_en_d;
      sh_opt_q      <= sh_opt_d;
      sh_psc_q      <= sh_psc_d;
      sh_lim_q      <= sh_lim_d;
`endif
    end
  end

  assign tmr_enable_interrupt   = act_en_q;
  assign tmr_interrupt_option   = act_opt_q;
  assign tmr_prescaler_selector = act_psc_q;
  assign tmr_limit_value        = act_lim_q;
  assign tmr_restart            = restart_q;
  assign owner_valid            = owner_valid_q;
  assign owner_id               = owner_id_q;

endmodule
